// File: rtl/btog_conv_arbiter_if.sv
// btog_conv_arbiter_if: request/result bundle between requesters, the shared Gray converter and its consumer
interface btog_conv_arbiter_if #(
  parameter int WIDTH   = 4,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_bin;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     out_valid;
  logic [WIDTH-1:0]         out_gray;
  logic [ID_W-1:0]          out_id;
  logic                     out_ready;
  logic [CNT_W-1:0]         conv_count;
  modport slave (
    input  req_valid, req_bin, out_ready,
    output req_ready, out_valid, out_gray, out_id, conv_count
  );
  modport master (
    output req_valid, req_bin, out_ready,
    input  req_ready, out_valid, out_gray, out_id, conv_count
  );
endinterface

// File: rtl/btog_conv_arbiter.sv
// btog_conv_arbiter: round-robin shared binary-to-Gray converter with registered valid/ready output
module btog_conv_arbiter #(
  parameter int WIDTH   = 4,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  btog_conv_arbiter_if.slave  bus
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t             r_state, w_state_nxt;
  logic [ID_W-1:0]    r_ptr, w_gnt_idx, r_id;
  logic [WIDTH-1:0]   w_bin, r_gray;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_found, w_accept, w_drain;
  // Round-robin search: first valid requester at or above the pointer, wrapping
  always_comb begin
    int j;
    j = 0;
    w_found = 1'b0;
    w_gnt_idx = '0;
    w_bin = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(r_ptr) + k;
      j = (j >= NUM_REQ) ? j - NUM_REQ : j;
      if (!w_found && bus.req_valid[j]) begin
        w_found = 1'b1;
        w_gnt_idx = ID_W'(j);
        w_bin = bus.req_bin[j*WIDTH +: WIDTH];
      end
    end
  end
  // Accept when the result slot is free or being drained; reset masks any grant
  always_comb begin
    w_drain = (r_state == HOLD) & bus.out_ready;
    w_accept = rst_n & w_found & ((r_state == IDLE) | bus.out_ready);
    bus.req_ready = w_accept ? NUM_REQ'(1) << w_gnt_idx : '0;
    w_state_nxt = w_accept ? HOLD : (w_drain ? IDLE : r_state);
  end
  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end
  // Result register: Gray code and winner id captured on accept, held under backpressure
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_gray <= '0;
      r_id   <= '0;
    end else if (w_accept) begin
      r_gray <= w_bin ^ (w_bin >> 1);
      r_id   <= w_gnt_idx;
    end
  end
  // Pointer moves just past the winner, only when a grant happens
  always_ff @(posedge clk) begin
    if (!rst_n)        r_ptr <= '0;
    else if (w_accept) r_ptr <= (int'(w_gnt_idx) == NUM_REQ - 1) ? '0 : w_gnt_idx + 1'b1;
  end
  // Saturating count of output handshakes
  always_ff @(posedge clk) begin
    if (!rst_n)                      r_cnt <= '0;
    else if (w_drain && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
  end
  assign bus.out_valid  = (r_state == HOLD);
  assign bus.out_gray   = r_gray;
  assign bus.out_id     = r_id;
  assign bus.conv_count = r_cnt;
endmodule

// File: tb/tb_btog_conv_arbiter.sv
// tb_btog_conv_arbiter: directed checks of arbitration, Gray datapath, backpressure, counter and reset
module tb_btog_conv_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int n_chk = 0;
  int n_err = 0;
  btog_conv_arbiter_if #(.WIDTH(4), .NUM_REQ(4), .ID_W(2), .CNT_W(4)) bus ();
  btog_conv_arbiter #(.WIDTH(4), .NUM_REQ(4), .ID_W(2), .CNT_W(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  logic [3:0] gray_tab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                               4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
  logic [1:0] id_tab [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  initial begin
    rst_n = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_bin = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("t1_ready", 32'(bus.req_ready), 32'h0);
    chk("t1_valid", 32'(bus.out_valid), 32'h0);
    chk("t1_count", 32'(bus.conv_count), 32'h0);
    chk("t1_gray", 32'(bus.out_gray), 32'h0);
    chk("t1_id", 32'(bus.out_id), 32'h0);
    rst_n = 1'b1;
    bus.req_valid = 4'b0001;
    bus.req_bin[3:0] = 4'b0101;
    #1;
    chk("t2_ready", 32'(bus.req_ready), 32'b0001);
    tick();
    chk("t2_valid", 32'(bus.out_valid), 32'h1);
    chk("t2_gray", 32'(bus.out_gray), 32'b0111);
    chk("t2_id", 32'(bus.out_id), 32'h0);
    bus.req_valid = 4'b0100;
    for (int i = 0; i < 16; i++) begin
      bus.req_bin[11:8] = 4'(i);
      #1;
      chk("t3_ready", 32'(bus.req_ready), 32'b0100);
      tick();
      chk("t3_gray", 32'(bus.out_gray), 32'(gray_tab[i]));
      chk("t3_id", 32'(bus.out_id), 32'h2);
    end
    bus.req_valid = 4'b0000;
    tick();
    chk("t3_drained", 32'(bus.out_valid), 32'h0);
    chk("t3_count_sat", 32'(bus.conv_count), 32'hf);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t4_count_rst", 32'(bus.conv_count), 32'h0);
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t4_valid", 32'(bus.out_valid), 32'h1);
      chk("t4_id", 32'(bus.out_id), 32'(id_tab[i]));
    end
    bus.req_valid = 4'b0000;
    tick();
    chk("t4_count", 32'(bus.conv_count), 32'h6);
    bus.req_valid = 4'b0010;
    bus.req_bin[7:4] = 4'b1000;
    bus.out_ready = 1'b0;
    tick();
    chk("t5_gray", 32'(bus.out_gray), 32'b1100);
    chk("t5_id", 32'(bus.out_id), 32'h1);
    for (int i = 0; i < 5; i++) begin
      bus.req_bin[7:4] = 4'(i + 3);
      #1;
      chk("t5_ready_low", 32'(bus.req_ready), 32'h0);
      tick();
      chk("t5_hold_valid", 32'(bus.out_valid), 32'h1);
      chk("t5_hold_gray", 32'(bus.out_gray), 32'b1100);
      chk("t5_hold_id", 32'(bus.out_id), 32'h1);
      chk("t5_hold_count", 32'(bus.conv_count), 32'h6);
    end
    bus.req_valid = 4'b0000;
    bus.out_ready = 1'b1;
    tick();
    chk("t5_count", 32'(bus.conv_count), 32'h7);
    chk("t5_valid", 32'(bus.out_valid), 32'h0);
    bus.req_valid = 4'b0100;
    bus.out_ready = 1'b0;
    tick();
    chk("t6_valid_pre", 32'(bus.out_valid), 32'h1);
    chk("t6_id_pre", 32'(bus.out_id), 32'h2);
    rst_n = 1'b0;
    tick();
    chk("t6_valid_rst", 32'(bus.out_valid), 32'h0);
    chk("t6_count_rst", 32'(bus.conv_count), 32'h0);
    rst_n = 1'b1;
    bus.req_valid = 4'b1010;
    bus.out_ready = 1'b1;
    #1;
    chk("t6_ready", 32'(bus.req_ready), 32'b0010);
    tick();
    chk("t6_id", 32'(bus.out_id), 32'h1);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
